peri_reg_fabric: RTL and testbench

- Parametrised register-bus splitter for peripheral wrappers; replaces hand-written fixed two-slot decode/response muxing.
- Decodes one master reg bus into NUM_SLV slave slots using a configurable address field.
- Tracks each transaction with an FSM and timeout counter.
- Returns an error ack for unmapped or unresponsive slots and logs the first error address until cleared.

---
 rtl/peri_reg_fabric.sv | 173 +++++++++++++++++
 tb/tb_peri_reg_fabric.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/peri_reg_fabric.sv
// Register-bus splitter: decodes one master reg bus into NUM_SLV slave slots.
// Ports: mclk/reset_n, master reg_* bus, slave s_* bus, sticky error log.
module peri_reg_fabric #(
    parameter int NUM_SLV = 4,
    parameter int AW      = 11,
    parameter int SEL_MSB = 10,
    parameter int SEL_LSB = 7,
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 255
) (
    input  logic                  mclk,
    input  logic                  reset_n,
    input  logic                  reg_cs,
    input  logic                  reg_wr,
    input  logic [AW-1:0]         reg_addr,
    input  logic [31:0]           reg_wdata,
    input  logic [3:0]            reg_be,
    output logic [31:0]           reg_rdata,
    output logic                  reg_ack,
    output logic                  reg_err,
    output logic [NUM_SLV-1:0]    s_cs,
    output logic                  s_wr,
    output logic [AW-1:0]         s_addr,
    output logic [31:0]           s_wdata,
    output logic [3:0]            s_be,
    input  logic [32*NUM_SLV-1:0] s_rdata,
    input  logic [NUM_SLV-1:0]    s_ack,
    input  logic                  err_clr,
    output logic                  err_sticky,
    output logic [AW-1:0]         err_addr,
    output logic                  err_tmo
);

    localparam int SW = SEL_MSB - SEL_LSB + 1;
    // One extra bit so NUM_SLV == 2^SW is representable.
    localparam logic [SW:0] NSLV = (SW+1)'(NUM_SLV);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t               state;
    logic [SW-1:0]        sel;
    logic [SW-1:0]        sel_q;
    logic                 mapped;
    logic [NUM_SLV-1:0]   cs_dec;
    logic                 ack_hit;
    logic [31:0]          rdata_hit;
    logic                 wr_q;
    logic [AW-1:0]        addr_q;
    logic [TMO_W-1:0]     cnt;
    logic                 err_ev;
    logic                 err_ev_tmo;
    logic [AW-1:0]        err_ev_addr;

    assign s_wr    = reg_wr;
    assign s_addr  = reg_addr;
    assign s_wdata = reg_wdata;
    assign s_be    = reg_be;

    assign sel    = reg_addr[SEL_MSB:SEL_LSB];
    assign mapped = {1'b0, sel} < NSLV;

    // Loop-based select keeps index widths exact for any NUM_SLV.
    always_comb begin
        cs_dec    = '0;
        ack_hit   = 1'b0;
        rdata_hit = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            cs_dec[k] = (sel == SW'(k));
            if (sel_q == SW'(k)) begin
                ack_hit   = s_ack[k];
                rdata_hit = s_rdata[32*k +: 32];
            end
        end
    end

    // Error response being issued at this edge (unmapped or timeout).
    always_comb begin
        err_ev      = 1'b0;
        err_ev_tmo  = 1'b0;
        err_ev_addr = reg_addr;
        if (state == IDLE && reg_cs && !mapped) begin
            err_ev = 1'b1;
        end else if (state == BUSY && !ack_hit && cnt == TMO_LAST) begin
            err_ev      = 1'b1;
            err_ev_tmo  = 1'b1;
            err_ev_addr = addr_q;
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            s_cs      <= '0;
            reg_ack   <= 1'b0;
            reg_err   <= 1'b0;
            reg_rdata <= '0;
            sel_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    reg_ack   <= 1'b0;
                    reg_err   <= 1'b0;
                    reg_rdata <= '0;
                    if (reg_cs) begin
                        if (mapped) begin
                            state  <= BUSY;
                            sel_q  <= sel;
                            wr_q   <= reg_wr;
                            addr_q <= reg_addr;
                            cnt    <= '0;
                            s_cs   <= cs_dec;
                        end else begin
                            state   <= RESP;
                            reg_ack <= 1'b1;
                            reg_err <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    // Ack takes priority over a coincident timeout.
                    if (ack_hit) begin
                        state     <= RESP;
                        s_cs      <= '0;
                        reg_ack   <= 1'b1;
                        reg_err   <= 1'b0;
                        reg_rdata <= wr_q ? 32'h0 : rdata_hit;
                    end else if (cnt == TMO_LAST) begin
                        state     <= RESP;
                        s_cs      <= '0;
                        reg_ack   <= 1'b1;
                        reg_err   <= 1'b1;
                        reg_rdata <= '0;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    reg_ack   <= 1'b0;
                    reg_err   <= 1'b0;
                    reg_rdata <= '0;
                end
                default: begin
                    state <= IDLE;
                    s_cs  <= '0;
                end
            endcase
        end
    end

    // First-error log; a new error beats a coincident clear.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky <= 1'b0;
            err_addr   <= '0;
            err_tmo    <= 1'b0;
        end else if (err_ev && (!err_sticky || err_clr)) begin
            err_sticky <= 1'b1;
            err_addr   <= err_ev_addr;
            err_tmo    <= err_ev_tmo;
        end else if (err_clr && !err_ev) begin
            err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_peri_reg_fabric.sv
// Randomised bench for peri_reg_fabric against a transaction-level model.
// Ports: drives master bus, emulates slaves, checks responses and error log.
module tb_peri_reg_fabric;

    localparam int NS    = 4;
    localparam int AW    = 11;
    localparam int TMO   = 8;
    localparam int NEVER = 1000;

    logic              mclk = 1'b0;
    logic              reset_n = 1'b1;
    logic              reg_cs = 1'b0;
    logic              reg_wr = 1'b0;
    logic [AW-1:0]     reg_addr = '0;
    logic [31:0]       reg_wdata = '0;
    logic [3:0]        reg_be = '0;
    logic [31:0]       reg_rdata;
    logic              reg_ack;
    logic              reg_err;
    logic [NS-1:0]     s_cs;
    logic              s_wr;
    logic [AW-1:0]     s_addr;
    logic [31:0]       s_wdata;
    logic [3:0]        s_be;
    logic [32*NS-1:0]  s_rdata = '0;
    logic [NS-1:0]     s_ack = '0;
    logic              err_clr = 1'b0;
    logic              err_sticky;
    logic [AW-1:0]     err_addr;
    logic              err_tmo;

    peri_reg_fabric #(
        .NUM_SLV (NS),
        .AW      (AW),
        .SEL_MSB (10),
        .SEL_LSB (7),
        .TMO_W   (8),
        .TMO_CYC (TMO)
    ) dut (
        .mclk       (mclk),
        .reset_n    (reset_n),
        .reg_cs     (reg_cs),
        .reg_wr     (reg_wr),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_be     (reg_be),
        .reg_rdata  (reg_rdata),
        .reg_ack    (reg_ack),
        .reg_err    (reg_err),
        .s_cs       (s_cs),
        .s_wr       (s_wr),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_be       (s_be),
        .s_rdata    (s_rdata),
        .s_ack      (s_ack),
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
        .err_addr   (err_addr),
        .err_tmo    (err_tmo)
    );

    always #5 mclk = ~mclk;

    int n_cmp = 0;
    int n_bad = 0;

    bit            m_sticky = 0;
    logic [AW-1:0] m_addr = '0;
    bit            m_tmo = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_log();
        chk("err_sticky", err_sticky, m_sticky);
        chk("err_addr", err_addr, m_addr);
        chk("err_tmo", err_tmo, m_tmo);
    endtask

    // dly: BUSY-cycle index at which the slave acks (>= TMO means none).
    // clr_at: transaction cycle in which err_clr is pulsed (0 = none).
    task automatic txn(input logic [AW-1:0] addr, input bit wr,
                       input int dly, input int clr_at, input bit noise,
                       input logic [31:0] fix_data);
        int sel;
        bit mapped;
        logic [31:0] data [NS];
        int lat;
        int cs_exp;
        bit err;
        logic [31:0] rd;
        int cyc;
        int hi;
        int cs_n;
        bit got;
        bit bad_cs;
        logic [NS-1:0] mask;
        sel    = int'(addr[10:7]);
        mapped = sel < NS;
        for (int k = 0; k < NS; k++) begin
            data[k] = (fix_data != 0) ? fix_data : $urandom;
            s_rdata[32*k +: 32] = data[k];
        end
        if (!mapped) begin
            lat = 2; err = 1; rd = 0; cs_exp = 0;
        end else if (dly < TMO) begin
            lat = 3 + dly; err = 0; cs_exp = dly + 1;
            rd = wr ? 32'h0 : data[sel];
        end else begin
            lat = 2 + TMO; err = 1; rd = 0; cs_exp = TMO;
        end
        if (clr_at > 0) m_sticky = 0;
        if (err && !m_sticky) begin
            m_sticky = 1; m_addr = addr; m_tmo = mapped;
        end
        @(negedge mclk);
        reg_cs    = 1'b1;
        reg_wr    = wr;
        reg_addr  = addr;
        reg_wdata = $urandom;
        reg_be    = 4'($urandom);
        err_clr   = (clr_at == 1);
        s_ack     = '0;
        #1;
        chk("s_addr", s_addr, addr);
        chk("s_wdata", s_wdata, reg_wdata);
        cyc = 1; hi = 0; cs_n = 0; got = 0; bad_cs = 0;
        while (!got && cyc < TMO + 6) begin
            @(negedge mclk);
            cyc++;
            err_clr = (clr_at == cyc);
            s_ack   = '0;
            if (s_cs != '0) begin
                cs_n++;
                if (!mapped || s_cs != (NS'(1) << sel)) bad_cs = 1;
            end
            if (reg_ack) begin
                got = 1;
                chk("latency", cyc, lat);
                chk("reg_err", reg_err, err);
                chk("reg_rdata", reg_rdata, rd);
                reg_cs  = 1'b0;
                err_clr = 1'b0;
            end else if (mapped) begin
                if (s_cs[sel]) begin
                    if (hi == dly) s_ack[sel] = 1'b1;
                    hi++;
                end
                if (noise) begin
                    mask  = ~(NS'(1) << sel);
                    s_ack = s_ack | (NS'($urandom) & mask);
                end
            end
        end
        if (!got) begin
            chk("ack_timeout", 0, 1);
            reg_cs = 1'b0;
            err_clr = 1'b0;
            s_ack = '0;
        end
        chk("cs_cycles", cs_n, cs_exp);
        chk("cs_onehot", bad_cs, 0);
        chk_log();
    endtask

    // Quiet cycles, optionally with a stray ack, expecting no response.
    task automatic quiet(input int n, input logic [NS-1:0] ack);
        for (int i = 0; i < n; i++) begin
            @(negedge mclk);
            s_ack = ack;
            chk("quiet_ack", reg_ack, 0);
            chk("quiet_cs", s_cs, 0);
        end
        @(negedge mclk);
        s_ack = '0;
    endtask

    initial begin
        int d;
        int c;
        logic [AW-1:0] a;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ack", reg_ack, 0);
        chk("rst_err", reg_err, 0);
        chk("rst_rdata", reg_rdata, 0);
        chk("rst_cs", s_cs, 0);
        chk_log();
        repeat (2) @(negedge mclk);
        reset_n = 1'b1;

        txn(11'h100, 0, 0, 0, 0, 32'hA5A5_1234);
        txn(11'h600, 1, 0, 0, 0, 0);
        txn(11'h080, 0, NEVER, 0, 0, 0);
        quiet(2, 4'b0010);
        txn(11'h080, 0, NEVER, TMO + 1, 0, 0);
        txn(11'h000, 0, TMO - 1, 0, 0, 0);
        txn(11'h010, 0, 2, 0, 1, 0);
        txn(11'h020, 1, 1, 0, 1, 0);

        @(negedge mclk);
        err_clr = 1'b1;
        @(negedge mclk);
        err_clr = 1'b0;
        m_sticky = 0;
        chk_log();

        for (int i = 0; i < 40; i++) begin
            a = AW'($urandom);
            d = $urandom_range(0, TMO + 1);
            if ($urandom_range(0, 5) == 0) d = NEVER;
            c = 0;
            if ($urandom_range(0, 3) == 0) begin
                if (a[10:7] >= NS) c = 1;
                else if (d < TMO) c = $urandom_range(1, 2 + d);
                else c = $urandom_range(1, 1 + TMO);
            end
            txn(a, 1'($urandom), d, c, 1'($urandom), 0);
            if ($urandom_range(0, 3) == 0) quiet(1, NS'($urandom));
        end

        @(negedge mclk);
        reg_cs   = 1'b1;
        reg_wr   = 1'b0;
        reg_addr = 11'h000;
        repeat (3) @(negedge mclk);
        chk("busy_cs", s_cs, 4'b0001);
        reset_n = 1'b0;
        reg_cs  = 1'b0;
        #1;
        m_sticky = 0; m_addr = '0; m_tmo = 0;
        chk("rst_mid_cs", s_cs, 0);
        chk("rst_mid_ack", reg_ack, 0);
        chk_log();
        @(negedge mclk);
        reset_n = 1'b1;
        quiet(4, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
